// File: rtl/weight_load_ctrl.sv
// Weight tile sequencer: streams K rows into every column FIFO, then issues K read pulses and a done pulse after the skew tail.
// Write lands 1 cycle after accept; done comes K+SYS_COLS cycles after compute_start. s_ready is high only in LOAD and drops after the K-th row.
module weight_load_ctrl #(
    parameter int SYS_COLS   = 4,
    parameter int W_BITWIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic [CW-1:0]                  cfg_rows,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [SYS_COLS*W_BITWIDTH-1:0] s_data,
    input  logic                           compute_start,
    output logic [SYS_COLS-1:0]            wb_wr_en,
    output logic [SYS_COLS*W_BITWIDTH-1:0] wb_data,
    output logic                           wb_read,
    output logic                           loaded,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    typedef enum logic [2:0] {IDLE, LOAD, READY, READ, FLUSH} state_t;

    localparam int            FW         = $clog2(SYS_COLS + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(SYS_COLS - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

    state_t        state;
    logic [CW-1:0] k_rows;
    logic [CW-1:0] row_cnt;
    logic [CW-1:0] rd_cnt;
    logic [FW-1:0] fl_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k_rows   <= '0;
            row_cnt  <= '0;
            rd_cnt   <= '0;
            fl_cnt   <= '0;
            s_ready  <= 1'b0;
            wb_wr_en <= '0;
            wb_data  <= '0;
            wb_read  <= 1'b0;
            loaded   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            wb_wr_en <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays high through the done cycle and clears here
                    busy <= 1'b0;
                    if (load_start) begin
                        if (cfg_rows != '0 && cfg_rows <= DEPTH_C) begin
                            k_rows  <= cfg_rows;
                            row_cnt <= '0;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        wb_data  <= s_data;
                        wb_wr_en <= '1;
                        row_cnt  <= row_cnt + CW'(1);
                        if (row_cnt + CW'(1) == k_rows) begin
                            s_ready <= 1'b0;
                            loaded  <= 1'b1;
                            state   <= READY;
                        end
                    end
                end
                READY: begin
                    if (compute_start) begin
                        loaded  <= 1'b0;
                        rd_cnt  <= CW'(1);
                        wb_read <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (rd_cnt == k_rows) begin
                        wb_read <= 1'b0;
                        if (SYS_COLS == 1) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            fl_cnt <= FW'(1);
                            state  <= FLUSH;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                end
                FLUSH: begin
                    // last column trails column 0 by SYS_COLS-1 cycles
                    if (fl_cnt == FLUSH_LAST) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        fl_cnt <= fl_cnt + FW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl; expected events are queued by the stimulus and matched by a monitor.
module tb_weight_load_ctrl;

    localparam int SC = 4;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    localparam int EV_WR   = 1;
    localparam int EV_RD   = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [CW-1:0]     cfg_rows = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [SC*W-1:0]   s_data = '0;
    logic              compute_start = 1'b0;
    logic [SC-1:0]     wb_wr_en;
    logic [SC*W-1:0]   wb_data;
    logic              wb_read;
    logic              loaded;
    logic              busy;
    logic              done;
    logic              cfg_err;

    weight_load_ctrl #(
        .SYS_COLS(SC), .W_BITWIDTH(W), .DEPTH(D), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .cfg_rows(cfg_rows),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .compute_start(compute_start), .wb_wr_en(wb_wr_en), .wb_data(wb_data),
        .wb_read(wb_read), .loaded(loaded), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              kind;
        int              cyc;
        logic [SC*W-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int c, input logic [SC*W-1:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue
    ev_t mon_e;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: kind %0d never seen, expected at cycle %0d, now %0d",
                     mon_e.kind, mon_e.cyc, cyc);
        end
        for (int kk = EV_WR; kk <= EV_ERR; kk++) begin
            logic present;
            present = (kk == EV_WR)   ? (wb_wr_en != '0) :
                      (kk == EV_RD)   ? wb_read :
                      (kk == EV_DONE) ? done : cfg_err;
            if (present) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == kk) begin
                    mon_e = exp_q.pop_front();
                    if (kk == EV_WR && (wb_data !== mon_e.data || wb_wr_en !== 4'hF)) begin
                        errors++;
                        $display("FAIL write_data: got en=%0h data=%0h expected en=f data=%0h (cycle %0d)",
                                 wb_wr_en, wb_data, mon_e.data, cyc);
                    end
                end else begin
                    errors++;
                    $display("FAIL unexpected_event: kind %0d seen at cycle %0d, not expected", kk, cyc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int k);
        load_start = 1'b1;
        cfg_rows   = CW'(k);
        tick();
        load_start    = 1'b0;
        compute_start = 1'b0;
    endtask

    task automatic send_row(input logic [SC*W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        push(EV_WR, cyc + 1, d);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic readout(input int k);
        int c;
        c = cyc;
        chk("loaded_before_read", loaded, 1);
        compute_start = 1'b1;
        for (int i = 1; i <= k; i++) push(EV_RD, c + i, '0);
        push(EV_DONE, c + k + SC, '0);
        tick();
        compute_start = 1'b0;
        chk("loaded_drops", loaded, 0);
        chk("busy_reading", busy, 1);
        while (cyc < c + k + SC) tick();
        chk("busy_in_done_cycle", busy, 1);
        tick();
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [SC*W-1:0] rows [3];
        int c;
        rows[0] = 32'h04030201;
        rows[1] = 32'h08070605;
        rows[2] = 32'h0C0B0A09;

        // Reset held with active stimulus
        s_valid = 1'b1; load_start = 1'b1; cfg_rows = CW'(3); s_data = 32'hDEADBEEF;
        tick(); tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_en", wb_wr_en, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_read", wb_read, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        s_valid = 1'b0; load_start = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_after_rst_busy", busy, 0);
        chk("idle_after_rst_ready", s_ready, 0);

        // Back-to-back load of 3 rows
        start_load(3);
        chk("load_s_ready", s_ready, 1);
        chk("load_busy", busy, 1);
        for (int i = 0; i < 3; i++) send_row(rows[i]);
        chk("b2b_ready_drop", s_ready, 0);
        chk("b2b_loaded", loaded, 1);
        readout(3);

        // compute_start in IDLE is ignored
        compute_start = 1'b1;
        tick();
        compute_start = 1'b0;
        chk("idle_compute_busy", busy, 0);

        // Gapped load with a stray compute_start during LOAD
        start_load(3);
        send_row(rows[2]);
        compute_start = 1'b1;
        tick();
        compute_start = 1'b0;
        send_row(rows[1]);
        tick();
        chk("gap_not_loaded", loaded, 0);
        chk("gap_ready_held", s_ready, 1);
        send_row(rows[0]);
        chk("gap_loaded", loaded, 1);
        tick(); tick();
        readout(3);

        // Illegal row counts
        push(EV_ERR, cyc + 1, '0);
        start_load(0);
        chk("err0_busy", busy, 0);
        chk("err0_ready", s_ready, 0);
        tick();
        push(EV_ERR, cyc + 1, '0);
        start_load(17);
        chk("err17_busy", busy, 0);
        chk("err17_ready", s_ready, 0);
        tick();

        // Full-depth tile; the 17th row must be refused
        start_load(16);
        for (int i = 0; i < 16; i++) send_row(32'h11111111 * (i + 1));
        chk("full_ready_drop", s_ready, 0);
        s_valid = 1'b1; s_data = 32'hFFFFFFFF;
        tick(); tick();
        chk("row17_refused", s_ready, 0);
        s_valid = 1'b0;
        readout(16);

        // Simultaneous load/compute in IDLE: load wins, then reset mid-READ
        compute_start = 1'b1;
        start_load(4);
        chk("simul_load_wins", s_ready, 1);
        for (int i = 0; i < 4; i++) send_row(32'hA0A0A0A0 + i);
        c = cyc;
        compute_start = 1'b1;
        push(EV_RD, c + 1, '0);
        push(EV_RD, c + 2, '0);
        tick();
        compute_start = 1'b0;
        tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_wb_read", wb_read, 0);
        chk("abort_busy", busy, 0);
        chk("abort_loaded", loaded, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_idle", busy, 0);

        // Normal operation resumes
        start_load(1);
        send_row(32'h55AA55AA);
        readout(1);

        tick(); tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
